sram_pipe: RTL and testbench

//   Parametrised single-clock simple-dual-port SRAM: one read port, one byte-masked write port.

---
 rtl/sram_pipe.sv | 168 ++++++++++++++++
 tb/tb_sram_pipe.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_pipe.sv
// sram_pipe: single-clock simple-dual-port SRAM with one read port and one
// byte-masked write port. Configurable width, depth and read latency (1 or 2),
// optional same-address write-to-read bypass and an optional post-reset
// clear sequencer that zeroes one word per cycle.
module sram_pipe #(
    parameter int WIDTH          = 32,
    parameter int DEPTH          = 1024,
    parameter int READ_LAT       = 1,
    parameter int BYPASS         = 1,
    parameter int CLEAR_ON_RESET = 1,
    localparam int LOGDEPTH      = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1,
    localparam int LANES         = WIDTH / 8
) (
    input  logic                clk,
    input  logic                reset,
    output logic                busy,
    input  logic                read_req,
    input  logic [LOGDEPTH-1:0] read_addr,
    output logic [WIDTH-1:0]    read_data,
    output logic                read_valid,
    input  logic                write_req,
    input  logic [LOGDEPTH-1:0] write_addr,
    input  logic [LANES-1:0]    write_byte_en,
    input  logic [WIDTH-1:0]    write_data
);

    // Depth extended by one bit so out-of-range addresses compare correctly
    // even when DEPTH is a power of two.
    localparam logic [LOGDEPTH:0]   DEPTH_EXT = (LOGDEPTH + 1)'(DEPTH);
    localparam logic [LOGDEPTH-1:0] LAST_ADDR = LOGDEPTH'(DEPTH - 1);

    typedef enum logic {
        CLEAR,
        READY
    } state_e;

    state_e              state_q, state_d;
    logic [LOGDEPTH-1:0] clr_cnt_q, clr_cnt_d;
    logic                clr_we;

    logic [WIDTH-1:0]    mem_q [DEPTH];

    logic                rd_in_range;
    logic                wr_in_range;
    logic                rd_acc;
    logic                wr_acc;
    logic [WIDTH-1:0]    rd_old;
    logic [WIDTH-1:0]    rd_word;

    logic                s1_valid_q;
    logic [WIDTH-1:0]    s1_data_q;
    logic                out_valid_d;
    logic [WIDTH-1:0]    out_data_d;
    logic                read_valid_q;
    logic [WIDTH-1:0]    read_data_q;

    // State register and clear counter; reset restarts the clear at word 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Next-state logic, clear-write strobe and busy flag.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_we    = 1'b0;
        busy      = 1'b0;
        if (reset) begin
            busy = 1'b1;
        end else begin
            case (state_q)
                CLEAR: begin
                    busy   = 1'b1;
                    clr_we = 1'b1;
                    if (clr_cnt_q == LAST_ADDR) begin
                        state_d = READY;
                    end else begin
                        clr_cnt_d = clr_cnt_q + 1'b1;
                    end
                end
                READY: begin
                    state_d = READY;
                end
                default: begin
                    state_d = READY;
                end
            endcase
        end
    end

    // Request qualification and array read with optional write bypass.
    always_comb begin
        rd_in_range = ({1'b0, read_addr} < DEPTH_EXT);
        wr_in_range = ({1'b0, write_addr} < DEPTH_EXT);
        rd_acc      = read_req & ~busy;
        wr_acc      = write_req & ~busy & wr_in_range;
        rd_old      = rd_in_range ? mem_q[read_addr] : '0;
        rd_word     = rd_old;
        // wr_acc already implies an in-range address, so an out-of-range read
        // can never pick up bypassed write data.
        if ((BYPASS != 0) && wr_acc && (read_addr == write_addr)) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (write_byte_en[i]) begin
                    rd_word[8*i +: 8] = write_data[8*i +: 8];
                end
            end
        end
    end

    // Storage: clear sequencer has priority; user writes are lane-masked.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[clr_cnt_q] <= '0;
        end else if (wr_acc) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (write_byte_en[i]) begin
                    mem_q[write_addr][8*i +: 8] <= write_data[8*i +: 8];
                end
            end
        end
    end

    // Optional second read stage, used only when READ_LAT is 2.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
        end else begin
            s1_valid_q <= rd_acc;
            if (rd_acc) begin
                s1_data_q <= rd_word;
            end
        end
    end

    // Select the source feeding the output register according to latency.
    always_comb begin
        out_valid_d = rd_acc;
        out_data_d  = rd_word;
        if (READ_LAT == 2) begin
            out_valid_d = s1_valid_q;
            out_data_d  = s1_data_q;
        end
    end

    // Output register: data holds between results, valid is a one-cycle strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            read_valid_q <= 1'b0;
            read_data_q  <= '0;
        end else begin
            read_valid_q <= out_valid_d;
            if (out_valid_d) begin
                read_data_q <= out_data_d;
            end
        end
    end

    assign read_valid = read_valid_q;
    assign read_data  = read_data_q;

endmodule

// File: tb/tb_sram_pipe.sv
// tb_sram_pipe: three sram_pipe instances share one stimulus bus.
//   A: DEPTH=16, READ_LAT=1, BYPASS=1, CLEAR_ON_RESET=1
//   B: DEPTH=12, READ_LAT=2, BYPASS=0, CLEAR_ON_RESET=1
//   C: DEPTH=16, READ_LAT=1, BYPASS=1, CLEAR_ON_RESET=0 (reads gated until initialised)
// A behavioural model per instance pushes expected read results into a
// scoreboard queue when a read is issued; they are popped when due.
module tb_sram_pipe;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rreq;
    logic [3:0]  raddr;
    logic        wreq;
    logic [3:0]  waddr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        c_en;
    logic        rreq_c;

    logic        bsy [3];
    logic        vld [3];
    logic [31:0] dat [3];

    assign rreq_c = rreq & c_en;

    sram_pipe #(.WIDTH(32), .DEPTH(16), .READ_LAT(1), .BYPASS(1), .CLEAR_ON_RESET(1)) u_a (
        .clk(clk), .reset(rst), .busy(bsy[0]),
        .read_req(rreq), .read_addr(raddr), .read_data(dat[0]), .read_valid(vld[0]),
        .write_req(wreq), .write_addr(waddr), .write_byte_en(be), .write_data(wdata)
    );

    sram_pipe #(.WIDTH(32), .DEPTH(12), .READ_LAT(2), .BYPASS(0), .CLEAR_ON_RESET(1)) u_b (
        .clk(clk), .reset(rst), .busy(bsy[1]),
        .read_req(rreq), .read_addr(raddr), .read_data(dat[1]), .read_valid(vld[1]),
        .write_req(wreq), .write_addr(waddr), .write_byte_en(be), .write_data(wdata)
    );

    sram_pipe #(.WIDTH(32), .DEPTH(16), .READ_LAT(1), .BYPASS(1), .CLEAR_ON_RESET(0)) u_c (
        .clk(clk), .reset(rst), .busy(bsy[2]),
        .read_req(rreq_c), .read_addr(raddr), .read_data(dat[2]), .read_valid(vld[2]),
        .write_req(wreq), .write_addr(waddr), .write_byte_en(be), .write_data(wdata)
    );

    typedef struct {
        logic [31:0] data;
        int          due;
    } rd_t;

    rd_t         sb0 [$];
    rd_t         sb1 [$];
    rd_t         sb2 [$];

    logic [31:0] mm [3][16];
    bit          mclr [3];
    int          mcnt [3];
    logic [31:0] mdat [3];
    int          edge_n;
    int          n_tests;
    int          n_fail;

    function automatic int dep(input int d);
        return (d == 1) ? 12 : 16;
    endfunction

    function automatic int lat(input int d);
        return (d == 1) ? 2 : 1;
    endfunction

    function automatic bit byp(input int d);
        return (d == 1) ? 1'b0 : 1'b1;
    endfunction

    function automatic bit clr(input int d);
        return (d == 2) ? 1'b0 : 1'b1;
    endfunction

    function automatic string nm(input int d);
        return (d == 0) ? "A" : ((d == 1) ? "B" : "C");
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) r[8*i +: 8] = nw[8*i +: 8];
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    task automatic sb_push(input int d, input rd_t e);
        case (d)
            0:       sb0.push_back(e);
            1:       sb1.push_back(e);
            default: sb2.push_back(e);
        endcase
    endtask

    task automatic sb_flush(input int d);
        case (d)
            0:       sb0.delete();
            1:       sb1.delete();
            default: sb2.delete();
        endcase
    endtask

    task automatic sb_take(input int d, output bit hit, output logic [31:0] data);
        rd_t e;
        hit  = 1'b0;
        data = '0;
        case (d)
            0: if (sb0.size() > 0 && sb0[0].due == edge_n) begin e = sb0.pop_front(); hit = 1'b1; end
            1: if (sb1.size() > 0 && sb1[0].due == edge_n) begin e = sb1.pop_front(); hit = 1'b1; end
            default: if (sb2.size() > 0 && sb2[0].due == edge_n) begin e = sb2.pop_front(); hit = 1'b1; end
        endcase
        if (hit) data = e.data;
    endtask

    // Model of one instance at a rising edge, using the inputs held across it.
    task automatic model_edge(input int d);
        rd_t         e;
        logic [31:0] v;
        bit          rq_d;
        rq_d = rreq && ((d != 2) || c_en);
        if (rst) begin
            sb_flush(d);
            mclr[d] = clr(d);
            mcnt[d] = 0;
        end else if (mclr[d]) begin
            mm[d][mcnt[d]] = '0;
            if (mcnt[d] == dep(d) - 1) mclr[d] = 1'b0;
            else                       mcnt[d]++;
        end else begin
            if (rq_d) begin
                v = (int'(raddr) < dep(d)) ? mm[d][raddr] : 32'h0;
                if (byp(d) && wreq && (waddr == raddr) && (int'(waddr) < dep(d)))
                    v = merge(v, wdata, be);
                e.data = v;
                e.due  = edge_n + lat(d) - 1;
                sb_push(d, e);
            end
            if (wreq && (int'(waddr) < dep(d)))
                mm[d][waddr] = merge(mm[d][waddr], wdata, be);
        end
    endtask

    task automatic model_check(input int d);
        bit          hit;
        logic [31:0] v;
        bit          exp_busy;
        exp_busy = rst || mclr[d];
        if (rst) begin
            sb_flush(d);
            hit     = 1'b0;
            mdat[d] = '0;
        end else begin
            sb_take(d, hit, v);
            if (hit) mdat[d] = v;
        end
        chk($sformatf("%s_busy", nm(d)),  32'(bsy[d]), 32'(exp_busy));
        chk($sformatf("%s_valid", nm(d)), 32'(vld[d]), 32'(hit));
        chk($sformatf("%s_data", nm(d)),  dat[d], mdat[d]);
    endtask

    task automatic step(input logic r, input logic rq, input logic [3:0] ra, input logic wq,
                        input logic [3:0] wa, input logic [3:0] b, input logic [31:0] wd);
        rst   = r;
        rreq  = rq;
        raddr = ra;
        wreq  = wq;
        waddr = wa;
        be    = b;
        wdata = wd;
        @(posedge clk);
        edge_n++;
        for (int d = 0; d < 3; d++) model_edge(d);
        #1;
        for (int d = 0; d < 3; d++) model_check(d);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 32'h0);
    endtask

    task automatic rd(input logic [3:0] a);
        step(1'b0, 1'b1, a, 1'b0, 4'd0, 4'd0, 32'h0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
        step(1'b0, 1'b0, 4'd0, 1'b1, a, b, d);
    endtask

    task automatic rnd_step();
        logic [3:0] wa;
        logic [3:0] ra;
        wa = 4'($urandom_range(0, 15));
        ra = ($urandom_range(0, 2) == 0) ? wa : 4'($urandom_range(0, 15));
        step(1'b0, 1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)), wa,
             4'($urandom_range(0, 15)), $urandom);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        edge_n  = 0;
        c_en    = 1'b0;
        for (int d = 0; d < 3; d++) begin
            mclr[d] = 1'b0;
            mcnt[d] = 0;
            mdat[d] = '0;
            for (int a = 0; a < 16; a++) mm[d][a] = '0;
        end

        // Power-up reset, then the clear sequence with reads pending while busy.
        step(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 32'h0);
        step(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 32'h0);
        for (int i = 0; i < 16; i++) begin
            chk("t1_busy_during_clear", 32'(bsy[0]), 32'd1);
            rd(4'd5);
        end
        chk("t1_busy_after_16", 32'(bsy[0]), 32'd0);
        rd(4'd5);
        chk("t1_rd5_valid", 32'(vld[0]), 32'd1);
        chk("t1_rd5_data", dat[0], 32'h0);
        idle();
        chk("t1_valid_single_pulse", 32'(vld[0]), 32'd0);

        // Fill every word so all instances hold known contents.
        for (int i = 0; i < 16; i++)
            wr(4'(i), (i == 7) ? 32'h0 : 32'h10 + 32'(i), 4'hF);
        c_en = 1'b1;

        // Byte-lane merge.
        wr(4'd3, 32'hAABBCCDD, 4'b1111);
        wr(4'd3, 32'h11223344, 4'b0101);
        rd(4'd3);
        chk("t2_merge_A", dat[0], 32'hAA22CC44);
        idle();
        chk("t2_merge_B_valid", 32'(vld[1]), 32'd1);
        chk("t2_merge_B", dat[1], 32'hAA22CC44);

        // Same-cycle same-address read/write collision.
        step(1'b0, 1'b1, 4'd7, 1'b1, 4'd7, 4'b0011, 32'hDEADBEEF);
        chk("t3_bypass_A", dat[0], 32'h0000BEEF);
        chk("t3_bypass_C", dat[2], 32'h0000BEEF);
        idle();
        chk("t3_readfirst_B", dat[1], 32'h0);
        rd(4'd7);
        idle();
        chk("t3_written_B", dat[1], 32'h0000BEEF);

        // Back-to-back reads through the two-stage pipeline.
        rd(4'd0);
        chk("t4_A0", dat[0], 32'h10);
        chk("t4_B_not_yet", 32'(vld[1]), 32'd0);
        rd(4'd1);
        chk("t4_B0_valid", 32'(vld[1]), 32'd1);
        chk("t4_B0", dat[1], 32'h10);
        rd(4'd2);
        chk("t4_B1", dat[1], 32'h11);
        idle();
        chk("t4_B2_valid", 32'(vld[1]), 32'd1);
        chk("t4_B2", dat[1], 32'h12);
        idle();
        chk("t4_B_valid_drop", 32'(vld[1]), 32'd0);

        // Out-of-range write and read on the 12-word instance.
        wr(4'd13, 32'hFFFFFFFF, 4'hF);
        rd(4'd13);
        chk("t6_A13", dat[0], 32'hFFFFFFFF);
        idle();
        chk("t6_B13_valid", 32'(vld[1]), 32'd1);
        chk("t6_B13_zero", dat[1], 32'h0);
        for (int i = 0; i < 12; i++) rd(4'(i));
        idle();
        idle();

        // Random traffic with frequent collisions.
        for (int i = 0; i < 300; i++) rnd_step();
        idle();
        idle();

        // Reset mid-clear with a read in flight; requests while busy are ignored.
        rd(4'd3);
        step(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 32'h0);
        chk("t5_inflight_dropped_B", 32'(vld[1]), 32'd0);
        for (int i = 0; i < 9; i++) idle();
        chk("t5_busy_at_cnt9", 32'(bsy[0]), 32'd1);
        step(1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 32'h0);
        for (int i = 0; i < 16; i++) begin
            rnd_step();
            chk("t5_restart_busy_A", 32'(bsy[0]), (i < 15) ? 32'd1 : 32'd0);
        end
        for (int i = 0; i < 16; i++) rd(4'(i));
        idle();
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
